// File: rtl/ultrasonic_echo.sv
// Echo pulse-width meter: synchronizes the sensor echo line and reports the
// high-time of the last completed pulse in prescaled ticks on `value`.
module ultrasonic_echo #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1,
    parameter int WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             signal,
    output logic [WIDTH-1:0] value
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX   = PW'(TICK_DIV - 1);
    // The rise cycle is the first prescaler phase, so value = floor(high cycles / TICK_DIV)
    localparam logic [PW-1:0]    PRESC_START = (TICK_DIV > 1) ? PW'(1) : '0;
    localparam logic [WIDTH-1:0] COUNT_START = (TICK_DIV == 1) ? WIDTH'(1) : '0;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q;
    logic [PW-1:0]          presc_q, presc_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       value_q, value_d;
    logic                   s;
    logic                   rise;
    logic                   tick;

    assign s     = sync_q[SYNC_STAGES-1];
    assign rise  = s & ~s_d_q;
    assign value = value_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], signal};
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        value_d = value_q;
        tick    = (presc_q == PRESC_MAX);

        case (state_q)
            IDLE: begin
                if (rise) begin
                    count_d = COUNT_START;
                    presc_d = PRESC_START;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!s) begin
                    value_d = count_q;
                    state_d = IDLE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    // Saturate rather than wrap on very long echoes
                    if (tick && (count_q != {WIDTH{1'b1}})) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            s_d_q   <= 1'b0;
            presc_q <= '0;
            count_q <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            s_d_q   <= s;
            presc_q <= presc_d;
            count_q <= count_d;
            value_q <= value_d;
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo.sv
// Self-checking bench for ultrasonic_echo: two instances (TICK_DIV=1 and 100)
// share the echo line and are compared against a floor(width/div) model.
module tb_ultrasonic_echo;

    localparam int SYNC  = 2;
    localparam int DIV_B = 100;

    logic        clk;
    logic        rst_n;
    logic        signal;
    logic [15:0] value_a;
    logic [15:0] value_b;

    int checks = 0;
    int errors = 0;

    ultrasonic_echo #(.SYNC_STAGES(SYNC), .TICK_DIV(1), .WIDTH(16)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .signal (signal),
        .value  (value_a)
    );

    ultrasonic_echo #(.SYNC_STAGES(SYNC), .TICK_DIV(DIV_B), .WIDTH(16)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .signal (signal),
        .value  (value_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a pulse seen high at n rising edges reports floor(n/div), capped at 16 bits
    function automatic logic [15:0] model(input int unsigned n, input int unsigned div);
        int unsigned t;
        t = n / div;
        if (t > 65535) t = 65535;
        return t[15:0];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        signal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            signal = ~signal;
            cycles(1);
            checks++;
            if (value_a !== 16'd0) begin
                errors++;
                $display("[TB] FAIL reset_a cyc%0d: got %0d, expected 0", i, value_a);
            end
            checks++;
            if (value_b !== 16'd0) begin
                errors++;
                $display("[TB] FAIL reset_b cyc%0d: got %0d, expected 0", i, value_b);
            end
        end
    endtask

    task automatic test_nominal();
        signal = 1'b1;
        rst_n  = 1'b1;
        cycles(5000);
        signal = 1'b0;
        cycles(SYNC);
        checks++;
        if (value_a !== 16'd0) begin
            errors++;
            $display("[TB] FAIL nominal_early: got %0d, expected 0", value_a);
        end
        cycles(1);
        checks++;
        if (value_a !== model(5000, 1)) begin
            errors++;
            $display("[TB] FAIL nominal_latency: got %0d, expected %0d", value_a, model(5000, 1));
        end
        checks++;
        if (value_b !== model(5000, DIV_B)) begin
            errors++;
            $display("[TB] FAIL prescale: got %0d, expected %0d", value_b, model(5000, DIV_B));
        end
        for (int i = 0; i < 4; i++) begin
            cycles(250);
            checks++;
            if (value_a !== 16'd5000) begin
                errors++;
                $display("[TB] FAIL nominal_hold%0d: got %0d, expected 5000", i, value_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        signal = 1'b1;
        cycles(10);
        signal = 1'b0;
        cycles(5);
        checks++;
        if (value_a !== 16'd10) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %0d, expected 10", value_a);
        end
        signal = 1'b1;
        cycles(20);
        checks++;
        if (value_a !== 16'd10) begin
            errors++;
            $display("[TB] FAIL b2b_during: got %0d, expected 10", value_a);
        end
        cycles(17);
        signal = 1'b0;
        cycles(SYNC + 1);
        checks++;
        if (value_a !== 16'd37) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %0d, expected 37", value_a);
        end
        // One-cycle low gap is the tightest legal spacing
        cycles(4);
        signal = 1'b1;
        cycles(4);
        signal = 1'b0;
        cycles(1);
        signal = 1'b1;
        cycles(5);
        checks++;
        if (value_a !== 16'd4) begin
            errors++;
            $display("[TB] FAIL gap1_first: got %0d, expected 4", value_a);
        end
        cycles(1);
        signal = 1'b0;
        cycles(SYNC + 1);
        checks++;
        if (value_a !== 16'd6) begin
            errors++;
            $display("[TB] FAIL gap1_second: got %0d, expected 6", value_a);
        end
        cycles(3);
    endtask

    task automatic test_random();
        int unsigned w;
        for (int i = 0; i < 20; i++) begin
            w = $urandom_range(1, 250);
            signal = 1'b1;
            cycles(int'(w));
            signal = 1'b0;
            cycles(SYNC + 1);
            checks++;
            if (value_a !== model(w, 1)) begin
                errors++;
                $display("[TB] FAIL rand_a%0d w=%0d: got %0d, expected %0d", i, w, value_a, model(w, 1));
            end
            checks++;
            if (value_b !== model(w, DIV_B)) begin
                errors++;
                $display("[TB] FAIL rand_b%0d w=%0d: got %0d, expected %0d", i, w, value_b, model(w, DIV_B));
            end
            cycles(int'($urandom_range(1, 10)));
        end
    endtask

    task automatic test_saturation();
        signal = 1'b1;
        cycles(30000);
        checks++;
        if (value_a === 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL sat_inflight: got %0d, expected previous result", value_a);
        end
        cycles(35600);
        signal = 1'b0;
        cycles(SYNC + 1);
        checks++;
        if (value_a !== model(65600, 1)) begin
            errors++;
            $display("[TB] FAIL saturation: got %0d, expected %0d", value_a, model(65600, 1));
        end
        checks++;
        if (value_b !== model(65600, DIV_B)) begin
            errors++;
            $display("[TB] FAIL sat_div: got %0d, expected %0d", value_b, model(65600, DIV_B));
        end
        cycles(5);
    endtask

    task automatic test_mid_reset();
        signal = 1'b1;
        cycles(1000);
        rst_n = 1'b0;
        cycles(1);
        checks++;
        if (value_a !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midrst_a: got %0d, expected 0", value_a);
        end
        checks++;
        if (value_b !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midrst_b: got %0d, expected 0", value_b);
        end
        cycles(1);
        rst_n = 1'b1;
        cycles(1000);
        checks++;
        if (value_a !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midrst_during: got %0d, expected 0", value_a);
        end
        cycles(998);
        signal = 1'b0;
        cycles(SYNC + 1);
        checks++;
        if (value_a !== model(1998, 1)) begin
            errors++;
            $display("[TB] FAIL midrst_partial: got %0d, expected %0d", value_a, model(1998, 1));
        end
        checks++;
        if (value_b !== model(1998, DIV_B)) begin
            errors++;
            $display("[TB] FAIL midrst_div: got %0d, expected %0d", value_b, model(1998, DIV_B));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        signal = 1'b0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
